// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: PC sequencer states, op/select/cause codes and exception vectors.
package cpu_pkg;

    localparam int unsigned PC_OP_W  = 3;
    localparam int unsigned PC_SRC_W = 3;
    localparam int unsigned CAUSE_W  = 2;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TMO_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EPC  = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_LOAD = 3'd4
    } state_t;

    localparam logic [PC_OP_W-1:0] OP_INC  = PC_OP_W'(0);
    localparam logic [PC_OP_W-1:0] OP_JR   = PC_OP_W'(1);
    localparam logic [PC_OP_W-1:0] OP_J    = PC_OP_W'(2);
    localparam logic [PC_OP_W-1:0] OP_BR   = PC_OP_W'(3);
    localparam logic [PC_OP_W-1:0] OP_ERET = PC_OP_W'(4);

    localparam logic [PC_SRC_W-1:0] SRC_REGA   = PC_SRC_W'(0);
    localparam logic [PC_SRC_W-1:0] SRC_ALU    = PC_SRC_W'(1);
    localparam logic [PC_SRC_W-1:0] SRC_JMP    = PC_SRC_W'(2);
    localparam logic [PC_SRC_W-1:0] SRC_ALUOUT = PC_SRC_W'(3);
    localparam logic [PC_SRC_W-1:0] SRC_EPC    = PC_SRC_W'(4);
    localparam logic [PC_SRC_W-1:0] SRC_EXC    = PC_SRC_W'(5);

    localparam logic [CAUSE_W-1:0] CAUSE_NONE   = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CAUSE_OPCODE = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_OVF    = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] CAUSE_DIV0   = CAUSE_W'(3);

    localparam logic [ADDR_W-1:0] VEC_OPCODE = ADDR_W'(253);
    localparam logic [ADDR_W-1:0] VEC_OVF    = ADDR_W'(254);
    localparam logic [ADDR_W-1:0] VEC_DIV0   = ADDR_W'(255);

    // Last count value in ST_WAIT: counts 0..254 give 255 wait cycles before the forced load.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(254);

    function automatic logic [ADDR_W-1:0] vec_of(input logic [CAUSE_W-1:0] c);
        logic [ADDR_W-1:0] v;
        v = '0;
        case (c)
            CAUSE_OPCODE: v = VEC_OPCODE;
            CAUSE_OVF:    v = VEC_OVF;
            CAUSE_DIV0:   v = VEC_DIV0;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Handshake bundle between main control / memory and the PC sequencer.
interface pc_seq_ctrl_if;
    import cpu_pkg::*;

    logic                 pc_req;
    logic [PC_OP_W-1:0]   pc_op;
    logic                 br_taken;
    logic                 exc_opcode;
    logic                 exc_ovf;
    logic                 exc_div0;
    logic                 mem_ack;
    logic [PC_SRC_W-1:0]  pc_src;
    logic                 pc_write;
    logic                 epc_write;
    logic                 excp_rd;
    logic [ADDR_W-1:0]    excp_addr;
    logic [CAUSE_W-1:0]   cause;
    logic                 busy;

    modport master (
        output pc_req, pc_op, br_taken, exc_opcode, exc_ovf, exc_div0, mem_ack,
        input  pc_src, pc_write, epc_write, excp_rd, excp_addr, cause, busy
    );

    modport slave (
        input  pc_req, pc_op, br_taken, exc_opcode, exc_ovf, exc_div0, mem_ack,
        output pc_src, pc_write, epc_write, excp_rd, excp_addr, cause, busy
    );

endinterface

// File: rtl/pc_seq_ctrl.sv
// PC update sequencer: same-cycle PC updates in idle, multi-cycle exception entry
// (EPC save, vector read with timeout, vector load).
module pc_seq_ctrl
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    pc_seq_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;

    logic                pc_write;
    logic [PC_SRC_W-1:0] pc_src;
    logic                epc_write;
    logic                excp_rd;
    logic [ADDR_W-1:0]   excp_addr;
    logic                busy;
    logic                any_exc;

    assign any_exc = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;

    // State, cause and timeout registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_d     = '0;
        pc_write  = 1'b0;
        pc_src    = SRC_ALU;
        epc_write = 1'b0;
        excp_rd   = 1'b0;
        excp_addr = '0;
        busy      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                // Idle decode is combinational, so gate it while reset is asserted.
                if (reset_n) begin
                    if (any_exc) begin
                        if (bus.exc_opcode)   cause_d = CAUSE_OPCODE;
                        else if (bus.exc_ovf) cause_d = CAUSE_OVF;
                        else                  cause_d = CAUSE_DIV0;
                        state_d = ST_EPC;
                    end else if (bus.pc_req) begin
                        case (bus.pc_op)
                            OP_INC: begin
                                pc_write = 1'b1;
                                pc_src   = SRC_ALU;
                            end
                            OP_JR: begin
                                pc_write = 1'b1;
                                pc_src   = SRC_REGA;
                            end
                            OP_J: begin
                                pc_write = 1'b1;
                                pc_src   = SRC_JMP;
                            end
                            OP_BR: begin
                                if (bus.br_taken) begin
                                    pc_write = 1'b1;
                                    pc_src   = SRC_ALUOUT;
                                end
                            end
                            OP_ERET: begin
                                pc_write = 1'b1;
                                pc_src   = SRC_EPC;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_EPC: begin
                epc_write = 1'b1;
                state_d   = ST_RD;
            end
            ST_RD: begin
                excp_rd   = 1'b1;
                excp_addr = vec_of(cause_q);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                excp_addr = vec_of(cause_q);
                if (bus.mem_ack || (cnt_q == TMO_LAST)) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ST_LOAD: begin
                excp_addr = vec_of(cause_q);
                pc_write  = 1'b1;
                pc_src    = SRC_EXC;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.pc_write  = pc_write;
    assign bus.pc_src    = pc_src;
    assign bus.epc_write = epc_write;
    assign bus.excp_rd   = excp_rd;
    assign bus.excp_addr = excp_addr;
    assign bus.cause     = cause_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus random traffic
// against a cycle-offset model of exception entry.
module tb_pc_seq_ctrl;

    logic clk;
    logic reset_n;

    pc_seq_ctrl_if bus();

    pc_seq_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model: t = cycles since the exception flag was accepted (0 = idle),
    // load_at = value of t at which the vector load happens (0 = not yet known).
    int         t;
    int         load_at;
    logic [1:0] cause_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    task automatic check_outputs(input logic e_pw, input logic [2:0] e_src, input logic e_epc,
                                 input logic e_rd, input logic [31:0] e_addr, input logic e_busy);
        check("pc_write",  32'(bus.pc_write),  32'(e_pw));
        check("pc_src",    32'(bus.pc_src),    32'(e_src));
        check("epc_write", 32'(bus.epc_write), 32'(e_epc));
        check("excp_rd",   32'(bus.excp_rd),   32'(e_rd));
        check("excp_addr", bus.excp_addr,      e_addr);
        check("cause",     32'(bus.cause),     32'(cause_m));
        check("busy",      32'(bus.busy),      32'(e_busy));
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance the model.
    task automatic step(input logic req, input logic [2:0] op, input logic br,
                        input logic eo, input logic ev, input logic ed, input logic ack);
        logic        e_pw, e_epc, e_rd, e_busy;
        logic [2:0]  e_src;
        logic [31:0] e_addr;
        @(negedge clk);
        bus.pc_req     = req;
        bus.pc_op      = op;
        bus.br_taken   = br;
        bus.exc_opcode = eo;
        bus.exc_ovf    = ev;
        bus.exc_div0   = ed;
        bus.mem_ack    = ack;
        #1;
        e_pw   = 1'b0;
        e_src  = 3'd1;
        e_epc  = 1'b0;
        e_rd   = 1'b0;
        e_addr = 32'd0;
        e_busy = (t != 0);
        if (t == 0) begin
            if (!(eo || ev || ed) && req) begin
                case (op)
                    3'd0: begin e_pw = 1'b1; e_src = 3'd1; end
                    3'd1: begin e_pw = 1'b1; e_src = 3'd0; end
                    3'd2: begin e_pw = 1'b1; e_src = 3'd2; end
                    3'd3: if (br) begin e_pw = 1'b1; e_src = 3'd3; end
                    3'd4: begin e_pw = 1'b1; e_src = 3'd4; end
                    default: ;
                endcase
            end
        end else begin
            e_epc = (t == 1);
            e_rd  = (t == 2);
            if (t >= 2) e_addr = 32'd252 + 32'(cause_m);
            if (t == load_at) begin
                e_pw  = 1'b1;
                e_src = 3'd5;
            end
        end
        check_outputs(e_pw, e_src, e_epc, e_rd, e_addr, e_busy);

        if (t == 0) begin
            if (eo || ev || ed) begin
                cause_m = eo ? 2'd1 : (ev ? 2'd2 : 2'd3);
                t = 1;
            end
        end else if (t == load_at) begin
            t = 0;
            load_at = 0;
        end else begin
            // Wait phase starts at t=3; 255 ack-less wait cycles end at t=257.
            if (t >= 3 && load_at == 0 && (ack || t == 257)) load_at = t + 1;
            t++;
        end
    endtask

    task automatic idle_step();
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int n;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        t       = 0;
        load_at = 0;
        cause_m = 2'd0;
        reset_n        = 1'b0;
        bus.pc_req     = 1'b0;
        bus.pc_op      = 3'd0;
        bus.br_taken   = 1'b0;
        bus.exc_opcode = 1'b0;
        bus.exc_ovf    = 1'b0;
        bus.exc_div0   = 1'b0;
        bus.mem_ack    = 1'b0;

        // Reset state
        #3;
        check_outputs(1'b0, 3'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_step();

        // Test 1: jump
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_src", 32'(bus.pc_src), 32'd2);

        // Test 2: branch not taken, then taken
        step(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_nt_pw", 32'(bus.pc_write), 32'd0);
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_tk_src", 32'(bus.pc_src), 32'd3);

        // Remaining single-cycle ops, including illegal codes
        for (int op = 0; op < 8; op++) step(1'b1, 3'(op), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 3: overflow beats simultaneous jump request, ack on third wait cycle
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_step();
        idle_step();
        check("t3_addr", bus.excp_addr, 32'd254);
        idle_step();
        idle_step();
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_load_src", 32'(bus.pc_src), 32'd5);
        check("t3_cause", 32'(bus.cause), 32'd2);
        idle_step();

        // ERET does not clear cause
        step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_step();

        // Test 4: opcode beats div0
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_step();
        idle_step();
        check("t4_addr", bus.excp_addr, 32'd253);
        check("t4_cause", 32'(bus.cause), 32'd1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_step();
        idle_step();

        // Test 5: no ack, timeout forces the load
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            idle_step();
            n++;
            if (bus.pc_write) break;
        end
        check("t5_len", 32'(n), 32'd258);
        idle_step();
        check("t5_busy", 32'(bus.busy), 32'd0);

        // Test 6: reset during wait
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle_step();
        @(negedge clk);
        reset_n = 1'b0;
        t       = 0;
        load_at = 0;
        cause_m = 2'd0;
        #1;
        check_outputs(1'b0, 3'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        check_outputs(1'b0, 3'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        reset_n = 1'b1;
        step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_inc_pw", 32'(bus.pc_write), 32'd1);
        idle_step();

        // Random traffic, including requests and acks while busy
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
